// File: rtl/ls259_ctrl_pkg.sv
// Shared types and widths for the LS259 write controller.
package ls259_ctrl_pkg;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LATCH_SEL_W = 3;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SETTLE,
        STROBE,
        HOLD
    } state_e;

endpackage

// File: rtl/ls259_wr_ctrl.sv
// CPU-bus write controller for a 74LS259 addressable latch: window decode,
// stability filter, single-cycle enable strobe, post-reset clear and a shadow copy.
module ls259_wr_ctrl
    import ls259_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = 16'hA000,
    parameter int unsigned          SETTLE     = 2,
    parameter int unsigned          CLR_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [7:0]             cpu_data,
    input  logic                   cpu_wr_b,
    output logic [LATCH_SEL_W-1:0] S,
    output logic                   D,
    output logic                   En_b,
    output logic                   clr_b,
    output logic [7:0]             shadow,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LATCH_SEL_W-1:0] s_q, s_d;
    logic                   d_q, d_d;
    logic                   en_b_q, en_b_d;
    logic                   clr_b_q, clr_b_d;
    logic [7:0]             shadow_q, shadow_d;
    logic                   busy_q, busy_d;

    logic match;
    logic bus_changed;

    assign match       = !cpu_wr_b && (cpu_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign bus_changed = (cpu_addr[2:0] != s_q) || (cpu_data[0] != d_q);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ls259_ctrl_pkg::CLEAR;
            cnt_q    <= CLR_LOAD;
            s_q      <= '0;
            d_q      <= 1'b0;
            en_b_q   <= 1'b1;
            clr_b_q  <= 1'b0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            d_q      <= d_d;
            en_b_q   <= en_b_d;
            clr_b_q  <= clr_b_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        d_d      = d_q;
        en_b_d   = 1'b1;
        clr_b_d  = clr_b_q;
        shadow_d = shadow_q;

        unique case (state_q)
            ls259_ctrl_pkg::CLEAR: begin
                clr_b_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ls259_ctrl_pkg::IDLE;
                    clr_b_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ls259_ctrl_pkg::IDLE: begin
                if (match) begin
                    s_d     = cpu_addr[2:0];
                    d_d     = cpu_data[0];
                    cnt_d   = SETTLE_LOAD;
                    state_d = ls259_ctrl_pkg::SETTLE;
                end
            end
            ls259_ctrl_pkg::SETTLE: begin
                // Loss of match is checked before the count so a write that
                // ends on the terminal edge never strobes.
                if (!match) begin
                    state_d = ls259_ctrl_pkg::IDLE;
                end else if (bus_changed) begin
                    s_d   = cpu_addr[2:0];
                    d_d   = cpu_data[0];
                    cnt_d = SETTLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ls259_ctrl_pkg::STROBE;
                    en_b_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ls259_ctrl_pkg::STROBE: begin
                shadow_d[s_q] = d_q;
                state_d       = ls259_ctrl_pkg::HOLD;
            end
            ls259_ctrl_pkg::HOLD: begin
                if (cpu_wr_b) begin
                    state_d = ls259_ctrl_pkg::IDLE;
                end
            end
            default: begin
                state_d = ls259_ctrl_pkg::CLEAR;
                cnt_d   = CLR_LOAD;
                clr_b_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ls259_ctrl_pkg::IDLE);
    end

    assign S      = s_q;
    assign D      = d_q;
    assign En_b   = en_b_q;
    assign clr_b  = clr_b_q;
    assign shadow = shadow_q;
    assign busy   = busy_q;

endmodule

// File: doc/ls259_wr_ctrl.md
# ls259_wr_ctrl

CPU-bus write controller that sits directly upstream of the 74LS259 addressable-latch model. It decodes CPU writes into the latch's 8-address window and qualifies them with a stability filter. It then issues a single-cycle active-low enable strobe with select/data held stable, and performs the post-reset clear sequence on the latch's `clr_b`. It also keeps a shadow copy of the eight latched bits for readback and debug.

## Interface
- `ADDR_W`, 16, CPU address width
- `BASE_ADDR`, 16'hA000, latch window base; bits [2:0] ignored; window is BASE_ADDR[ADDR_W-1:3], 8 addresses
- `SETTLE`, 2, cycles a write must stay stable before strobing; legal range 1..15
- `CLR_CYCLES`, 4, cycles `clr_b` is held low after reset release; legal range 1..15

- `clk`  in  1  system clock
- `rst_b`  in  1  reset, asynchronous, active-low; one clock domain
- `cpu_addr`  in  ADDR_W  CPU address bus, synchronous to `clk`
- `cpu_data`  in  8  CPU data bus; only bit 0 is latched
- `cpu_wr_b`  in  1  CPU write strobe, active-low
- `S`  out  3  latch select to LS259
- `D`  out  1  latch data to LS259
- `En_b`  out  1  latch enable, active-low, one-cycle pulse
- `clr_b`  out  1  latch clear, active-low
- `shadow`  out  8  mirror of the bits the latch holds
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs are registered.
- Reset values: `S`=0, `D`=0, `En_b`=1, `clr_b`=0, `shadow`=0, `busy`=1. The state is CLEAR and the counter is CLR_CYCLES-1.
- Match condition: `cpu_wr_b`==0 and `cpu_addr[ADDR_W-1:3]`==`BASE_ADDR[ADDR_W-1:3]`.
- CLEAR:
  - `clr_b`=0; the counter decrements each cycle.
  - When the counter reaches 0, go to IDLE and set `clr_b`=1.
  - All bus activity is ignored in this state.
- IDLE:
  - On match, capture `S`<=`cpu_addr[2:0]` and `D`<=`cpu_data[0]`, load the counter with SETTLE-1, and go to SETTLE.
- SETTLE:
  - If the match condition is lost, go to IDLE with no strobe (glitch rejected).
  - Else if `cpu_addr[2:0]`/`cpu_data[0]` differ from the captured values, recapture and reload SETTLE-1.
  - Else, if the counter is 0, go to STROBE; otherwise decrement.
- STROBE:
  - Exactly one cycle, with `En_b`=0.
  - `shadow[S]`<=`D` in the same cycle.
  - Unconditionally go to HOLD.
- HOLD:
  - Wait for `cpu_wr_b`==1, then go to IDLE.
  - A single long write produces exactly one strobe; a new strobe requires `cpu_wr_b` to be deasserted first.
- Invariant: `clr_b` and `En_b` are never both low (the latch treats that combination as illegal).

## Timing
- The edge that samples the match in IDLE is edge E0.
- With a stable bus, STROBE is entered at edge E0+SETTLE.
- `En_b` is low for the one clock period following edge E0+SETTLE.
- `shadow` updates at edge E0+SETTLE+1.
- `S`/`D` are valid from E0+1 (after the last recapture) and remain unchanged through the end of the `En_b` pulse; they hold until the next capture.
- `clr_b` rises at the CLR_CYCLES-th edge after `rst_b` deasserts.
- `rst_b` asserted at any time, including mid-STROBE, immediately forces the reset values; `En_b` returns high asynchronously.
- A write that deasserts exactly on the edge where the counter reaches 0 is rejected: the match is checked before the count.

## Structure
- Package `ls259_ctrl_pkg`:
  - state enum {CLEAR, IDLE, SETTLE, STROBE, HOLD}
  - `CNT_W`=4
  - `LATCH_SEL_W`=3
- The counter is shared between CLEAR and SETTLE.
- No sub-module; the FSM, counter and shadow register live in one module.
- The verification bench instantiates the block alongside `ls259` for an end-to-end check: `shadow` must equal the latch's `Q`.

## Test plan
- Reset release → `clr_b` low exactly 4 cycles then high; `En_b`=1 and `shadow`=0 throughout; no strobe even if `cpu_wr_b`=0 at `cpu_addr`=16'hA003 during CLEAR.
- Write 16'hA005, data 8'h01, held 6 cycles → one `En_b` pulse at E0+2 with `S`=5, `D`=1; `shadow`=8'h20; `busy` back low after `cpu_wr_b`=1.
- One-cycle `cpu_wr_b` glitch at 16'hA002 → no `En_b` pulse; `shadow` unchanged.
- Write to 16'hA010 (outside the window) → no strobe, `busy` stays 0. Write 16'hA001 with data changing 1→0 at E0+1 → single strobe with `D`=0 at E0+3.
- Assert `rst_b` during the STROBE cycle → `En_b` high immediately; `shadow`=0; full CLEAR sequence replays.
- Eight back-to-back writes to A000..A007 with data 1 → `shadow`=8'hFF and exactly 8 strobes; `clr_b` and `En_b` are never low in the same cycle.
